multdiv_unit: RTL and testbench
===============================

MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clock and reset.
REQ-002 clock  input  1  rising-edge clock shared with the pipeline registers.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-004 data_operandA  input  32  signed two's-complement multiplicand or dividend.
REQ-005 data_operandB  input  32  signed two's-complement multiplier or divisor.
REQ-006 ctrl_MULT  input  1  one-cycle start pulse for a multiply; issued by the execute stage.
REQ-007 ctrl_DIV  input  1  one-cycle start pulse for a divide; issued by the execute stage.
REQ-008 data_result  output  32  low 32 bits of the product, or the quotient.
REQ-009 data_exception  output  1  overflow on multiply, or divide-by-zero / overflow on divide.
REQ-010 data_resultRDY  output  1  one-cycle pulse; data_result and data_exception are valid.
REQ-011 busy  output  1  high while an operation is in flight; the execute stage uses it as a stall source.

Function
REQ-012 The block SHALL implement the states IDLE, MULT, DIV and DONE.
REQ-013 Operands SHALL be latched on the rising edge where ctrl_MULT or ctrl_DIV is 1 (the start edge); later changes to the operand inputs SHALL be ignored.
REQ-014 If ctrl_MULT and ctrl_DIV are both 1 on the same edge, multiply SHALL win.
REQ-015 A start pulse in any state, including MULT, DIV or DONE, SHALL abort the current operation and restart with the new operands; the aborted operation SHALL produce no resultRDY pulse.
REQ-016 Multiply SHALL be iterative radix-2 shift-add on operand magnitudes, one bit per cycle, for 32 iterations, followed by sign correction.
REQ-017 Divide SHALL be iterative restoring division on operand magnitudes for 32 iterations; the quotient truncates toward zero and its sign is the XOR of the operand signs.
REQ-018 Latency: data_resultRDY SHALL be 1 in exactly the cycle after the 33rd rising edge following the start edge (DONE state), for one cycle only.
REQ-019 Multiply exception SHALL be 1 when the 64-bit signed product is not the sign-extension of its low 32 bits; data_result SHALL be the low 32 bits regardless.
REQ-020 Divide by zero SHALL be detected at the start edge: go directly to DONE, resultRDY 1 cycle after the start edge, result 0, exception 1.
REQ-021 Division of 0x80000000 by 0xFFFFFFFF SHALL give result 0x80000000 with exception 1 at the normal latency.
REQ-022 data_result and data_exception SHALL hold their last values until the next DONE state or reset.
REQ-023 busy SHALL be 1 in MULT and DIV, and 0 in IDLE and DONE.
REQ-024 DONE SHALL return to IDLE after one cycle unless a start pulse occurs.
REQ-025 An internal 6-bit iteration counter SHALL clear on the start edge and stop at 32; it SHALL not wrap.

Reset
REQ-026 With reset=0: state = IDLE; data_result = 0; data_exception = 0; data_resultRDY = 0; busy = 0; counter and operand registers = 0.
REQ-027 Reset asserted mid-operation SHALL abandon the operation with no resultRDY pulse; the first start after reset release SHALL behave normally.

Structure
REQ-028 Package multdiv_pkg SHALL hold the state encoding (IDLE, MULT, DIV, DONE) and the constant ITER = 32.
REQ-029 One sub-module iter_counter (6-bit, synchronous clear, saturating enable, async active-low reset) SHALL be instantiated; the datapath and FSM SHALL stay in multdiv_unit.

Verification
REQ-030 Multiply: A = 7, B = -3, MULT pulse -> resultRDY at start+33, result 0xFFFFFFEB, exception 0.
REQ-031 Multiply overflow: A = 0x00010000, B = 0x00010000 -> result 0x00000000, exception 1.
REQ-032 Divide: A = -7, B = 2 -> result 0xFFFFFFFD, exception 0. Divide by zero: A = 5, B = 0 -> resultRDY at start+1, result 0, exception 1.
REQ-033 Restart: DIV 100/7 started, then a MULT 6*7 pulse at start+10 -> a single resultRDY at start+43, result 42; no pulse for the divide.
REQ-034 Reset: reset driven low at start+15 of a multiply -> all outputs 0 immediately; no resultRDY; the next DIV 9/3 -> result 3 at the normal latency.

Source files
------------

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared state encoding, iteration count and helpers for multdiv_unit
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int         ITER       = 32;
  localparam logic [5:0] ITER_COUNT = 6'(ITER);

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
  function automatic logic [31:0] magnitude(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/iter_counter.sv
// rtl/iter_counter.sv - 6-bit iteration counter, synchronous clear, saturates at ITER
module iter_counter
  import multdiv_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  output logic [5:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != ITER_COUNT) begin
      count <= count + 6'd1;
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - iterative signed 32x32 multiply (low word) and divide (quotient)
module multdiv_unit
  import multdiv_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  state_t      state, next_state;
  logic [5:0]  count;
  logic [31:0] a_mag, b_mag;
  logic [63:0] acc;
  logic        neg, dbz;
  logic        start, dbz_start, running, finish;
  logic [32:0] mult_sum, div_shift;
  logic [31:0] div_diff, div_signed;
  logic        div_ge;
  logic [63:0] mult_signed;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign dbz_start = ctrl_DIV & ~ctrl_MULT & (data_operandB == 32'd0);
  assign running   = (state == MULT) || (state == DIV);
  assign finish    = running && !start && (count == ITER_COUNT || dbz);

  iter_counter u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (start),
    .enable (running),
    .count  (count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A start pulse overrides whatever the current state would do next.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      next_state = IDLE;
      MULT, DIV: if (count == ITER_COUNT || dbz) next_state = DONE;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
    if (ctrl_MULT) begin
      next_state = MULT;
    end else if (ctrl_DIV) begin
      next_state = DIV;
    end
  end

  assign busy           = running;
  assign data_resultRDY = (state == DONE);

  // acc: multiply = {partial product, remaining multiplier bits}; divide = {remainder, dividend/quotient}.
  assign mult_sum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
  assign div_shift   = {acc[63:32], acc[31]};
  assign div_ge      = div_shift >= {1'b0, b_mag};
  assign div_diff    = div_shift[31:0] - b_mag;
  assign mult_signed = neg ? -acc : acc;
  assign div_signed  = neg ? -acc[31:0] : acc[31:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_mag          <= '0;
      b_mag          <= '0;
      acc            <= '0;
      neg            <= 1'b0;
      dbz            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      if (start) begin
        a_mag <= magnitude(data_operandA);
        b_mag <= magnitude(data_operandB);
        acc   <= {32'd0, ctrl_MULT ? magnitude(data_operandB) : magnitude(data_operandA)};
        neg   <= data_operandA[31] ^ data_operandB[31];
        dbz   <= dbz_start;
      end else if (running && count != ITER_COUNT) begin
        if (state == MULT) begin
          acc <= {mult_sum, acc[31:1]};
        end else begin
          acc <= {div_ge ? div_diff : div_shift[31:0], acc[30:0], div_ge};
        end
      end
      if (finish) begin
        if (state == MULT) begin
          data_result    <= mult_signed[31:0];
          data_exception <= mult_signed[63:32] != {32{mult_signed[31]}};
        end else if (dbz) begin
          data_result    <= '0;
          data_exception <= 1'b1;
        end else begin
          // Only 0x80000000 / -1 yields a positive quotient magnitude of 2^31.
          data_result    <= div_signed;
          data_exception <= ~neg & acc[31];
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - directed and random scoreboard bench for multdiv_unit
module tb_multdiv_unit;

  typedef struct {
    logic [31:0] r;
    logic        e;
    int          at;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint sa, sb_, p;
    sa = $signed(a);
    sb_ = $signed(b);
    if (m) begin
      p = sa * sb_;
      r = p[31:0];
      e = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0) begin
      r = '0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      p = sa / sb_;
      r = p[31:0];
      e = 1'b0;
    end
  endfunction

  // Returns at the negedge following the start edge; operands are scrambled afterwards.
  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                          input bit track);
    exp_t x;
    logic [31:0] r;
    logic e;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = m;
    ctrl_DIV = d;
    if (track) begin
      model(m, a, b, r, e);
      x.r = r;
      x.e = e;
      x.at = cyc + 1 + ((!m && b == 32'd0) ? 1 : 33);
      sb.push_back(x);
    end
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 120 && sb.size() != 0; i++) @(negedge clock);
    check({tag, "_drain"}, sb.size(), 0);
  endtask

  always @(negedge clock) begin
    exp_t x;
    if (reset && data_resultRDY) begin
      check("unexpected_rdy", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        x = sb.pop_front();
        check("result", data_result, x.r);
        check("exception", data_exception, x.e);
        check("latency", cyc, x.at);
        check("busy_done", busy, 0);
      end
    end
  end

  initial begin
    logic [31:0] a, b;
    int s;
    #2;
    check("rst_result", data_result, 0);
    check("rst_exception", data_exception, 0);
    check("rst_rdy", data_resultRDY, 0);
    check("rst_busy", busy, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    start_op(1, 0, 32'd7, 32'hFFFF_FFFD, 1);
    check("busy_mult", busy, 1);
    wait_drain("mul7x-3");
    start_op(1, 0, 32'h0001_0000, 32'h0001_0000, 1);
    wait_drain("mul_ovf");
    start_op(0, 1, 32'hFFFF_FFF9, 32'd2, 1);
    check("busy_div", busy, 1);
    wait_drain("div-7/2");
    start_op(0, 1, 32'd5, 32'd0, 1);
    wait_drain("div_by0");
    start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_drain("div_ovf");
    start_op(1, 1, 32'd6, 32'hFFFF_FFFD, 1);
    wait_drain("both_pulse");

    // Restart: divide aborted by a multiply whose start edge is 10 edges later.
    start_op(0, 1, 32'd100, 32'd7, 0);
    repeat (8) @(negedge clock);
    start_op(1, 0, 32'd6, 32'd7, 1);
    wait_drain("restart");

    // Reset 15 edges into a multiply; nothing may be reported for it.
    start_op(1, 0, 32'd1234, 32'd5678, 0);
    s = cyc;
    repeat (14) @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_edge", cyc, s + 15);
    check("midrst_result", data_result, 0);
    check("midrst_exception", data_exception, 0);
    check("midrst_rdy", data_resultRDY, 0);
    check("midrst_busy", busy, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    start_op(0, 1, 32'd9, 32'd3, 1);
    wait_drain("div9/3");

    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : $urandom_range(1, 5000);
      if (i % 4 == 3) b = -b;
      start_op(i % 2 == 0, i % 2 != 0, a, b, 1);
      wait_drain("random");
    end

    repeat (40) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
